// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage arithmetic units.
//   OP_*    : 3-bit ctl encodings of the iterative multiply/divide unit
//   state_t : control states of alu_mdu_iter
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/mdu_neg_abs.sv
// ---------------------------------------------------------------------------
// mdu_neg_abs
// Conditional two's-complement of a WIDTH-bit vector. Used both to take the
// magnitude of a signed operand and to re-apply the sign to a result.
//   i_data : input vector
//   i_neg  : 1 = output the two's-complement of i_data, 0 = pass through
//   o_data : result
// ---------------------------------------------------------------------------
module mdu_neg_abs #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_neg,
   output logic [WIDTH-1:0] o_data
);

   assign o_data = i_neg ? (~i_data + WIDTH'(1)) : i_data;

endmodule

// File: rtl/alu_mdu_iter.sv
// ---------------------------------------------------------------------------
// alu_mdu_iter
// Iterative radix-2 multiply/divide unit (MUL, MULH, MULHSU, MULHU, DIV,
// DIVU, REM, REMU). One shift-add / shift-subtract step per clock, operands
// held as magnitudes and the sign re-applied in a final FIX cycle.
//
// Ports:
//   clk, rst   : clock (rising edge), synchronous active-high reset
//   in_valid   : operands/op valid        in_ready  : accepting (IDLE only)
//   in1, in2   : rs1 / rs2 operands       ctl       : op select (alu_pkg OP_*)
//   out_valid  : result valid until taken out_ready : consumer takes result
//   result     : operation result         zero      : result == 0 (with out_valid)
//   busy       : unit is not IDLE
//
// Build option: define MDU_EARLY_OUT_EN to skip CALC for a zero divisor or a
// zero multiply operand (IDLE -> FIX -> DONE).
// ---------------------------------------------------------------------------
module alu_mdu_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [2:0]       ctl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy
);

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc;      // MUL: {hi, lo} product; DIV: {remainder, quotient}
   logic [WIDTH-1:0]   r_opd;      // multiplicand or divisor magnitude
   logic               r_neg, r_div, r_hi, r_rem, r_dz;
   logic [WIDTH-1:0]   r_result;
   logic               r_zero;

   // ---- operand decode and magnitudes -------------------------------------
   logic             w_sgn_a, w_sgn_b, w_div, w_rem, w_hi, w_neg_a, w_neg_b, w_skip;
   logic [WIDTH-1:0] w_abs_a, w_abs_b;

   assign w_sgn_a = (ctl == OP_MULH) || (ctl == OP_MULHSU) || (ctl == OP_DIV) || (ctl == OP_REM);
   assign w_sgn_b = (ctl == OP_MULH) || (ctl == OP_DIV) || (ctl == OP_REM);
   assign w_div   = !((ctl == OP_MUL) || (ctl == OP_MULH) || (ctl == OP_MULHSU) || (ctl == OP_MULHU));
   assign w_rem   = (ctl == OP_REM) || (ctl == OP_REMU);
   assign w_hi    = (ctl == OP_MULH) || (ctl == OP_MULHSU) || (ctl == OP_MULHU);
   assign w_neg_a = w_sgn_a && in1[WIDTH-1];
   assign w_neg_b = w_sgn_b && in2[WIDTH-1];

`ifdef MDU_EARLY_OUT_EN
   assign w_skip = (in2 == '0) || (!w_div && (in1 == '0));
`else
   assign w_skip = 1'b0;
`endif

   mdu_neg_abs #(.WIDTH(WIDTH)) u_abs_a (.i_data(in1), .i_neg(w_neg_a), .o_data(w_abs_a));
   mdu_neg_abs #(.WIDTH(WIDTH)) u_abs_b (.i_data(in2), .i_neg(w_neg_b), .o_data(w_abs_b));

   // ---- one iteration step -------------------------------------------------
   logic [WIDTH:0]     w_add, w_rem_sh;
   logic [WIDTH-1:0]   w_sub;
   logic               w_ge;
   logic [2*WIDTH-1:0] w_acc_step;

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_add      = '0;
      w_rem_sh   = '0;
      w_sub      = '0;
      w_ge       = 1'b0;
      w_acc_step = r_acc;
      if (r_div) begin
         // Shifted partial remainder can reach 2*divisor-1, hence WIDTH+1 bits.
         // When it is >= divisor the difference fits in WIDTH bits.
         w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
         w_ge       = (w_rem_sh >= {1'b0, r_opd});
         w_sub      = w_rem_sh[WIDTH-1:0] - r_opd;
         w_acc_step = w_ge ? {w_sub, r_acc[WIDTH-2:0], 1'b1}
                           : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      end else begin
         w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : {(WIDTH+1){1'b0}});
         w_acc_step = {w_add, r_acc[WIDTH-1:1]};
      end
   end

   // ---- FIX: sign correction and half/quotient/remainder select -----------
   logic [2*WIDTH-1:0] w_fix_in, w_fix_out;
   logic               w_dz_quot, w_fix_neg;
   logic [WIDTH-1:0]   w_fix_res;

   // A zero divisor forces the quotient to all-ones; the remainder magnitude
   // is already |in1| and takes the dividend sign, giving back in1.
   assign w_dz_quot = r_div && r_dz && !r_rem;
   assign w_fix_in  = r_div ? {{WIDTH{1'b0}}, (r_rem ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0])}
                            : r_acc;
   assign w_fix_neg = r_neg && !w_dz_quot;

   // Full-width negate so the high product half gets the borrow from the low half.
   mdu_neg_abs #(.WIDTH(2*WIDTH)) u_fix_neg (.i_data(w_fix_in), .i_neg(w_fix_neg), .o_data(w_fix_out));

   assign w_fix_res = w_dz_quot ? {WIDTH{1'b1}}
                    : (r_hi ? w_fix_out[2*WIDTH-1:WIDTH] : w_fix_out[WIDTH-1:0]);

   // ---- control: next state and handshake outputs -------------------------
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      unique case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) w_state_nxt = w_skip ? ST_FIX : ST_CALC;
         end
         ST_CALC: if (r_cnt == CNT_W'(WIDTH-1)) w_state_nxt = ST_FIX;
         ST_FIX:  w_state_nxt = ST_DONE;
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign result = r_result;
   assign zero   = r_zero && (r_state == ST_DONE);

   // ---- state and datapath registers --------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the datapath is reset along with control so result/zero come
         // out of reset at 0; there is no memory array here to leave unreset.
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opd    <= '0;
         r_neg    <= 1'b0;
         r_div    <= 1'b0;
         r_hi     <= 1'b0;
         r_rem    <= 1'b0;
         r_dz     <= 1'b0;
         r_result <= '0;
         r_zero   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         unique case (r_state)
            ST_IDLE: if (in_valid) begin
               r_cnt <= '0;
               r_opd <= w_div ? w_abs_b : w_abs_a;
               r_neg <= w_rem ? w_neg_a : (w_neg_a ^ w_neg_b);
               r_div <= w_div;
               r_hi  <= w_hi;
               r_rem <= w_rem;
               r_dz  <= (in2 == '0);
               if (w_skip) r_acc <= w_div ? {w_abs_a, {WIDTH{1'b0}}} : '0;
               else        r_acc <= w_div ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
            end
            ST_CALC: begin
               r_acc <= w_acc_step;
               r_cnt <= (r_cnt == CNT_W'(WIDTH-1)) ? '0 : r_cnt + CNT_W'(1);
            end
            ST_FIX: begin
               r_result <= w_fix_res;
               r_zero   <= (w_fix_res == '0);
            end
            default: ;
         endcase
      end
   end

endmodule
